tdm_slot_arbiter: RTL and testbench

- Scheduler that turns the per-cycle TDM calendar slot (chanSel from the calendar walker) plus live channel requests into an exclusive, held grant of the shared DMA datapath.
- Calendar owner wins its slot. Channels that keep missing their own slots are escalated to anti-starvation priority.
- Grant is held until the requester signals done, or until a watchdog timeout forces release.

---
 rtl/tdm_slot_arbiter_pkg.sv | 27 ++
 rtl/tdm_slot_arbiter_if.sv | 25 ++
 rtl/tdm_slot_arbiter_rr_pick.sv | 32 +++
 rtl/tdm_slot_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_tdm_slot_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdm_slot_arbiter_pkg.sv
// Shared types, constants and elaboration-time legality helpers for the TDM slot arbiter.
package tdm_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Cast to the slot width at the point of use; -1 yields all-ones at any width.
   localparam int IDLE_SLOT = -1;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic bit miss_thr_legal(input int thr, input int w);
      return (thr > 0) && (thr < (1 << w));
   endfunction

   function automatic bit tmo_max_legal(input int tmo, input int w);
      return (tmo > 0) && (tmo <= (1 << w));
   endfunction

endpackage

// File: rtl/tdm_slot_arbiter_if.sv
// Calendar/request/grant bundle between the calendar walker side and the slot arbiter.
interface tdm_slot_arbiter_if #(
   parameter int WIDTH = 5,
   parameter int NCHAN = 31
);
   logic [WIDTH-1:0] chanSel;
   logic [NCHAN-1:0] chanEn;
   logic [NCHAN-1:0] chanReq;
   logic             chanDone;
   logic             tmoClr;
   logic             gntValid;
   logic [WIDTH-1:0] gntChan;
   logic [NCHAN-1:0] gntVec;
   logic             tmoErr;

   modport master (
      output chanSel, chanEn, chanReq, chanDone, tmoClr,
      input  gntValid, gntChan, gntVec, tmoErr
   );

   modport slave (
      input  chanSel, chanEn, chanReq, chanDone, tmoClr,
      output gntValid, gntChan, gntVec, tmoErr
   );
endinterface

// File: rtl/tdm_slot_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module tdm_rr_pick #(
   parameter int N = 31,
   parameter int W = 5
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);
   logic [W-1:0] cand_idx [N];
   logic [N-1:0] rot;

   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] sum;
      assign sum          = {1'b0, ptr_i} + (W+1)'(gi);
      assign cand_idx[gi] = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);
      assign rot[gi]      = req_i[cand_idx[gi]];
   end

   // Scan downwards so the smallest rotation offset is the last to assign.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found_o = 1'b1;
            idx_o   = cand_idx[k];
         end
      end
   end
endmodule

// File: rtl/tdm_slot_arbiter.sv
// TDM slot arbiter: calendar owner / starved / optional work-conserving grant with watchdog.
// Optional feature macro: TDM_ARB_WORK_CONSERVE_EN (round-robin fallback on dead slots).
module tdm_slot_arbiter
   import tdm_arb_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int NCHAN    = 31,
   parameter int MISS_W   = 4,
   parameter int MISS_THR = 8,
   parameter int TMO_W    = 12,
   parameter int TMO_MAX  = 4000
) (
   input logic               clockCore,
   input logic               resetCore,
   tdm_slot_arbiter_if.slave arb_if
);
   localparam int              SLOTS     = 2 ** WIDTH;
   localparam logic [WIDTH-1:0] IDLE_CODE = WIDTH'(IDLE_SLOT);

   if (!miss_thr_legal(MISS_THR, MISS_W)) begin : g_bad_miss
      $error("MISS_THR must be in 1 .. 2**MISS_W-1");
   end
   if (!tmo_max_legal(TMO_MAX, TMO_W)) begin : g_bad_tmo
      $error("TMO_MAX must be in 1 .. 2**TMO_W");
   end
   if (clog2(NCHAN) > WIDTH) begin : g_bad_width
      $error("WIDTH too small for NCHAN");
   end

   arb_state_e       state_q, state_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [WIDTH-1:0] gnt_chan_q, gnt_chan_d;
   logic [NCHAN-1:0] gnt_vec_q, gnt_vec_d;
   logic             tmo_err_q, tmo_err_d;
   logic [WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [TMO_W-1:0] wdg_q, wdg_d;

   logic [NCHAN-1:0] eligible;
   logic [NCHAN-1:0] starved;
   logic [SLOTS-1:0] elig_pad;
   logic             owner_in_range;
   logic             owner_ok;
   logic             starv_found, fb_found;
   logic [WIDTH-1:0] starv_idx, fb_idx;
   logic             win_valid, win_rr, tmo_fire;
   logic [WIDTH-1:0] win_idx;

   assign eligible       = arb_if.chanReq & arb_if.chanEn;
   assign elig_pad       = SLOTS'(eligible);
   assign owner_in_range = {1'b0, arb_if.chanSel} < (WIDTH+1)'(NCHAN);
   assign owner_ok       = owner_in_range & elig_pad[arb_if.chanSel];

   for (genvar gi = 0; gi < NCHAN; gi++) begin : g_miss
      logic [MISS_W-1:0] miss_q, miss_d;
      logic              slot_hit, won, held;

      assign slot_hit    = owner_in_range & (arb_if.chanSel == WIDTH'(gi));
      assign won         = win_valid & (win_idx == WIDTH'(gi));
      assign held        = gnt_valid_q & (gnt_chan_q == WIDTH'(gi));
      assign starved[gi] = eligible[gi] & (miss_q == MISS_W'(MISS_THR));

      // Disable and grant both clear, and win over a same-cycle miss.
      always_comb begin
         miss_d = miss_q;
         if (!arb_if.chanEn[gi] || won) begin
            miss_d = '0;
         end else if (slot_hit && eligible[gi] && !held && miss_q != MISS_W'(MISS_THR)) begin
            miss_d = miss_q + 1'b1;
         end
      end

      always_ff @(posedge clockCore or negedge resetCore) begin
         if (!resetCore) miss_q <= '0;
         else            miss_q <= miss_d;
      end
   end

   tdm_rr_pick #(.N(NCHAN), .W(WIDTH)) u_starved_pick (
      .req_i   (starved),
      .ptr_i   (rr_ptr_q),
      .found_o (starv_found),
      .idx_o   (starv_idx)
   );

`ifdef TDM_ARB_WORK_CONSERVE_EN
   tdm_rr_pick #(.N(NCHAN), .W(WIDTH)) u_fallback_pick (
      .req_i   (eligible),
      .ptr_i   (rr_ptr_q),
      .found_o (fb_found),
      .idx_o   (fb_idx)
   );
`else
   assign fb_found = 1'b0;
   assign fb_idx   = '0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_valid_d = gnt_valid_q;
      gnt_chan_d  = gnt_chan_q;
      gnt_vec_d   = gnt_vec_q;
      rr_ptr_d    = rr_ptr_q;
      wdg_d       = wdg_q;
      win_valid   = 1'b0;
      win_idx     = '0;
      win_rr      = 1'b0;
      tmo_fire    = 1'b0;

      case (state_q)
         IDLE: begin
            if (starv_found) begin
               win_valid = 1'b1;
               win_idx   = starv_idx;
               win_rr    = 1'b1;
            end else if (owner_ok) begin
               win_valid = 1'b1;
               win_idx   = arb_if.chanSel;
            end else if (fb_found) begin
               win_valid = 1'b1;
               win_idx   = fb_idx;
               win_rr    = 1'b1;
            end

            if (win_valid) begin
               state_d     = BUSY;
               gnt_valid_d = 1'b1;
               gnt_chan_d  = win_idx;
               gnt_vec_d   = NCHAN'(1) << win_idx;
               wdg_d       = '0;
               if (win_rr) begin
                  rr_ptr_d = (win_idx == WIDTH'(NCHAN - 1)) ? '0 : win_idx + 1'b1;
               end
            end
         end

         BUSY: begin
            // A done in the timeout cycle is a clean release, not an error.
            if (arb_if.chanDone || wdg_q == TMO_W'(TMO_MAX - 1)) begin
               tmo_fire    = !arb_if.chanDone;
               state_d     = IDLE;
               gnt_valid_d = 1'b0;
               gnt_chan_d  = IDLE_CODE;
               gnt_vec_d   = '0;
            end else begin
               wdg_d = wdg_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      if (tmo_fire)           tmo_err_d = 1'b1;
      else if (arb_if.tmoClr) tmo_err_d = 1'b0;
      else                    tmo_err_d = tmo_err_q;
   end

   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         state_q     <= IDLE;
         gnt_valid_q <= 1'b0;
         gnt_chan_q  <= IDLE_CODE;
         gnt_vec_q   <= '0;
         tmo_err_q   <= 1'b0;
         rr_ptr_q    <= '0;
         wdg_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_chan_q  <= gnt_chan_d;
         gnt_vec_q   <= gnt_vec_d;
         tmo_err_q   <= tmo_err_d;
         rr_ptr_q    <= rr_ptr_d;
         wdg_q       <= wdg_d;
      end
   end

   assign arb_if.gntValid = gnt_valid_q;
   assign arb_if.gntChan  = gnt_chan_q;
   assign arb_if.gntVec   = gnt_vec_q;
   assign arb_if.tmoErr   = tmo_err_q;
endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Scoreboard bench for tdm_slot_arbiter: a rule-level model predicts every edge, a monitor compares.
module tb_tdm_slot_arbiter;
   localparam int WIDTH    = 5;
   localparam int NCHAN    = 31;
   localparam int MISS_THR = 8;
   localparam int TMO_MAX  = 4000;
`ifdef TDM_ARB_WORK_CONSERVE_EN
   localparam bit WC = 1'b1;
`else
   localparam bit WC = 1'b0;
`endif

   logic clockCore = 1'b0;
   logic resetCore = 1'b0;

   tdm_slot_arbiter_if #(.WIDTH(WIDTH), .NCHAN(NCHAN)) bus ();

   tdm_slot_arbiter dut (
      .clockCore (clockCore),
      .resetCore (resetCore),
      .arb_if    (bus)
   );

   always #5 clockCore = ~clockCore;

   typedef struct { bit valid; int chan; bit err; } exp_t;
   typedef struct { int chan; int edge_no; } gnt_t;

   exp_t exp_q[$];
   gnt_t gnt_q[$];
   int   errors = 0;
   int   checks = 0;
   int   edge_n = 0;

   // Reference model state (post-edge view).
   int   miss_m [NCHAN];
   int   rr_m;
   bit   busy_m;
   int   gch_m;
   int   wd_m;
   bit   err_m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_n);
      end
   endtask

   function automatic logic [NCHAN-1:0] bitv(input int c);
      logic [NCHAN-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   function automatic int rr_scan(input logic [NCHAN-1:0] v, input bit starved_only);
      for (int k = 0; k < NCHAN; k++) begin
         int c;
         c = (rr_m + k) % NCHAN;
         if (v[c] && (!starved_only || miss_m[c] == MISS_THR)) return c;
      end
      return -1;
   endfunction

   task automatic model_step(input int s, input logic [NCHAN-1:0] en, input logic [NCHAN-1:0] req,
                             input bit done, input bit clr, input bit rstn);
      logic [NCHAN-1:0] elig;
      int win;
      bit win_rr;
      bit set_err;
      exp_t e;
      gnt_t g;
      if (!rstn) begin
         foreach (miss_m[c]) miss_m[c] = 0;
         rr_m = 0; busy_m = 0; gch_m = 0; wd_m = 0; err_m = 0;
         e.valid = 0; e.chan = 31; e.err = 0;
         exp_q.push_back(e);
         return;
      end
      elig   = req & en;
      win    = -1;
      win_rr = 0;
      if (!busy_m) begin
         win = rr_scan(elig, 1'b1);
         if (win >= 0) win_rr = 1;
         else if (s < NCHAN && elig[s]) win = s;
         else if (WC) begin
            win = rr_scan(elig, 1'b0);
            win_rr = (win >= 0);
         end
      end
      if (s < NCHAN && elig[s] && s != win && !(busy_m && s == gch_m) && miss_m[s] < MISS_THR)
         miss_m[s]++;
      if (win >= 0) miss_m[win] = 0;
      for (int c = 0; c < NCHAN; c++) if (!en[c]) miss_m[c] = 0;
      set_err = 0;
      if (busy_m) begin
         if (done) busy_m = 0;
         else if (wd_m == TMO_MAX - 1) begin busy_m = 0; set_err = 1; end
         else wd_m++;
      end
      if (set_err) err_m = 1;
      else if (clr) err_m = 0;
      if (win >= 0) begin
         busy_m = 1; gch_m = win; wd_m = 0;
         if (win_rr) rr_m = (win + 1) % NCHAN;
         g.chan = win; g.edge_no = edge_n + 1;
         gnt_q.push_back(g);
      end
      e.valid = busy_m; e.chan = busy_m ? gch_m : 31; e.err = err_m;
      exp_q.push_back(e);
   endtask

   task automatic step(input int sel, input logic [NCHAN-1:0] en, input logic [NCHAN-1:0] req,
                       input bit done, input bit clr, input bit rstn);
      @(negedge clockCore);
      bus.chanSel  = WIDTH'(sel);
      bus.chanEn   = en;
      bus.chanReq  = req;
      bus.chanDone = done;
      bus.tmoClr   = clr;
      resetCore    = rstn;
      model_step(sel, en, req, done, clr, rstn);
   endtask

   task automatic after_edge();
      @(posedge clockCore);
      #2;
   endtask

   // Monitor: one expected state per edge, plus a grant record on every rising gntValid.
   initial begin : monitor
      bit   prev_valid;
      exp_t e;
      gnt_t g;
      prev_valid = 1'b0;
      forever begin
         @(posedge clockCore);
         #1;
         edge_n++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gntValid", 64'(bus.gntValid), 64'(e.valid));
            check("gntChan", 64'(bus.gntChan), 64'(e.chan));
            check("gntVec", 64'(bus.gntVec), e.valid ? 64'(bitv(e.chan)) : 64'd0);
            check("tmoErr", 64'(bus.tmoErr), 64'(e.err));
         end
         if (bus.gntValid === 1'b1 && !prev_valid) begin
            if (gnt_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: chan %0d at edge %0d, expected no grant", bus.gntChan, edge_n);
            end else begin
               g = gnt_q.pop_front();
               check("grant_chan", 64'(bus.gntChan), 64'(g.chan));
               check("grant_edge", 64'(edge_n), 64'(g.edge_no));
            end
         end
         prev_valid = (bus.gntValid === 1'b1);
      end
   end

   initial begin : driver
      logic [NCHAN-1:0] all_en;
      logic [NCHAN-1:0] en_r;
      logic [NCHAN-1:0] req_r;
      int sel_r;
      int guard;
      all_en       = '1;
      bus.chanSel  = '1;
      bus.chanEn   = '0;
      bus.chanReq  = '0;
      bus.chanDone = 1'b0;
      bus.tmoClr   = 1'b0;

      repeat (3) step(31, all_en, '0, 0, 0, 0);
      step(31, all_en, '0, 0, 0, 1);

      // Calendar grant, hold, done, bubble, re-grant.
      step(4, all_en, bitv(4), 0, 0, 1);
      after_edge();
      check("cal_grant_chan", 64'(bus.gntChan), 64'd4);
      repeat (3) step(4, all_en, '0, 0, 0, 1);
      step(4, all_en, bitv(4), 1, 0, 1);
      after_edge();
      check("done_release", 64'(bus.gntValid), 64'd0);
      step(4, all_en, bitv(4), 0, 0, 1);
      step(31, all_en, '0, 1, 0, 1);

      // Starvation: channel 7 misses eight slots while channel 2 holds.
      step(31, all_en, '0, 0, 0, 1);
      step(2, all_en, bitv(2), 0, 0, 1);
      repeat (8) step(7, all_en, bitv(2) | bitv(7), 0, 0, 1);
      step(31, all_en, bitv(7), 1, 0, 1);
      step(9, all_en, bitv(7) | bitv(9), 0, 0, 1);
      after_edge();
      check("starved_wins", 64'(bus.gntChan), 64'd7);
      step(31, all_en, '0, 1, 0, 1);

      // Reset mid-BUSY on channel 3, after channel 7 was starved again.
      step(31, all_en, '0, 0, 0, 1);
      step(3, all_en, bitv(3), 0, 0, 1);
      repeat (8) step(7, all_en, bitv(7), 0, 0, 1);
      step(3, all_en, bitv(3), 0, 0, 0);
      #1;
      check("rst_gntValid", 64'(bus.gntValid), 64'd0);
      check("rst_gntChan", 64'(bus.gntChan), 64'h1f);
      check("rst_gntVec", 64'(bus.gntVec), 64'd0);
      step(31, all_en, '0, 0, 0, 1);
      step(9, all_en, bitv(7) | bitv(9), 0, 0, 1);
      after_edge();
      check("miss_cleared_by_reset", 64'(bus.gntChan), 64'd9);
      step(31, all_en, '0, 1, 0, 1);

      // Watchdog timeout with a same-cycle tmoClr, then a lone tmoClr.
      step(1, all_en, bitv(1), 0, 0, 1);
      guard = 0;
      while (busy_m && guard < TMO_MAX + 10) begin
         step(31, all_en, '0, 0, (wd_m == TMO_MAX - 1), 1);
         guard++;
      end
      after_edge();
      check("tmo_err_set", 64'(bus.tmoErr), 64'd1);
      check("tmo_hold_cycles", 64'(guard), 64'(TMO_MAX));
      step(31, all_en, '0, 0, 1, 1);
      after_edge();
      check("tmo_err_clr", 64'(bus.tmoErr), 64'd0);

      // Done in the timeout cycle: clean release.
      step(1, all_en, bitv(1), 0, 0, 1);
      guard = 0;
      while (busy_m && guard < TMO_MAX + 10) begin
         step(31, all_en, '0, (wd_m == TMO_MAX - 1), 0, 1);
         guard++;
      end
      after_edge();
      check("done_at_tmo_no_err", 64'(bus.tmoErr), 64'd0);

      // Idle slots with channels 5 and 6 requesting.
      step(31, all_en, '0, 0, 0, 0);
      step(31, all_en, '0, 0, 0, 1);
      step(31, all_en, NCHAN'(32'h60), 0, 0, 1);
      after_edge();
      check("idle_slot_grant1", 64'(bus.gntChan), WC ? 64'd5 : 64'h1f);
      step(31, all_en, NCHAN'(32'h60), 1, 0, 1);
      step(31, all_en, NCHAN'(32'h60), 0, 0, 1);
      after_edge();
      check("idle_slot_grant2", 64'(bus.gntChan), WC ? 64'd6 : 64'h1f);
      step(31, all_en, '0, 1, 0, 1);

      // Disabled calendar owner never wins.
      repeat (10) step(4, all_en & ~bitv(4), bitv(4), 0, 0, 1);
      after_edge();
      check("disabled_no_grant", 64'(bus.gntValid), 64'd0);

      // Randomized traffic.
      en_r = all_en;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0)
            en_r = ($urandom_range(0, 1) == 0) ? all_en : (all_en & ~bitv(int'($urandom_range(0, NCHAN - 1))));
         sel_r = int'($urandom_range(0, 31));
         req_r = NCHAN'($urandom & $urandom & $urandom);
         if (sel_r < NCHAN && $urandom_range(0, 1) == 0) req_r |= bitv(sel_r);
         step(sel_r, en_r, req_r,
              busy_m ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 40) == 0), 1);
      end
      step(31, all_en, '0, 1, 0, 1);
      repeat (3) step(31, all_en, '0, 0, 0, 1);
      after_edge();
      check("grant_queue_drained", 64'(gnt_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
